// File: rtl/apb_timer_multi_if.sv
// APB bus bundle for the multi-channel timer: master drives the request,
// slave returns read data, ready and error.
interface apb_timer_multi_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_timer_multi.sv
// apb_timer_multi: NCH independent prescaled auto-reload up-counters on a
// zero-wait-state APB slave, with a shared W1C status register, an
// interrupt enable mask and one level interrupt.
//
// Map: 0x00 STATUS (W1C), 0x04 IRQ_EN, channel c at 0x10 + 0x10*c:
//   +0 CTRL {CLR(wo), ONESHOT, EN}, +4 PSC, +8 ARR, +C CNT (read-only).
module apb_timer_multi #(
  parameter int NCH    = 4,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 8
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_timer_multi_if.slave apb,
  output logic             irq
);

  // Highest channel block number that is populated (block 0 is global).
  localparam logic [3:0] LAST_BLK = 4'(NCH);

  // Address decode
  logic [ADDR_W-1:0] addr;
  logic [3:0]        blk;
  logic [1:0]        reg_sel;
  logic [3:0]        ch_idx;
  logic              hi_zero;
  logic              glob_sel;
  logic              ch_sel;
  logic              mapped;
  logic              acc;
  logic              wr_acc;
  logic              unused_addr;

  assign addr        = apb.PADDR;
  assign blk         = addr[7:4];
  assign reg_sel     = addr[3:2];
  assign ch_idx      = blk - 4'd1;
  assign hi_zero     = ((addr >> 8) == '0);
  // Only 0x00 and 0x04 exist in the global block; 0x08/0x0C are holes.
  assign glob_sel    = hi_zero && (blk == 4'd0) && !reg_sel[1];
  assign ch_sel      = hi_zero && (blk != 4'd0) && (blk <= LAST_BLK);
  assign mapped      = glob_sel || ch_sel;
  assign unused_addr = ^addr[1:0];

  assign acc    = apb.PSEL && apb.PENABLE;
  assign wr_acc = acc && apb.PWRITE;

  assign apb.PREADY  = acc;
  // CNT is read-only, so a write to it is flagged like an unmapped access.
  assign apb.PSLVERR = acc && (!mapped || (apb.PWRITE && ch_sel && (reg_sel == 2'd3)));

  // Per-channel state exported for readback
  logic [NCH-1:0]   en_r;
  logic [NCH-1:0]   os_r;
  logic [31:0]      psc_r [NCH];
  logic [CNT_W-1:0] arr_r [NCH];
  logic [CNT_W-1:0] cnt_r [NCH];
  logic [NCH-1:0]   ovf;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic             sel;
    logic             ctrl_we;
    logic             psc_we;
    logic             arr_we;
    logic             clr;
    logic             tick;
    logic             wrap;
    logic             en_q;
    logic             os_q;
    logic [31:0]      psc_q;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] arr_q;
    logic [CNT_W-1:0] cnt_q;

    assign sel     = wr_acc && ch_sel && (ch_idx == 4'(c));
    assign ctrl_we = sel && (reg_sel == 2'd0);
    assign psc_we  = sel && (reg_sel == 2'd1);
    assign arr_we  = sel && (reg_sel == 2'd2);
    assign clr     = ctrl_we && apb.PWDATA[2];
    // >= rather than == so shrinking PSC/ARR below the running count
    // recovers on the next cycle instead of running all the way round.
    assign tick    = en_q && (pc_q >= psc_q);
    // A same-cycle CLR wins over the overflow and cancels its flag.
    assign wrap    = tick && (cnt_q >= arr_q) && !clr;

    assign ovf[c]   = wrap;
    assign en_r[c]  = en_q;
    assign os_r[c]  = os_q;
    assign psc_r[c] = psc_q;
    assign arr_r[c] = arr_q;
    assign cnt_r[c] = cnt_q;

    // Control bits: a software CTRL write overrides the one-shot auto-stop.
    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        en_q <= 1'b0;
        os_q <= 1'b0;
      end else if (ctrl_we) begin
        en_q <= apb.PWDATA[0];
        os_q <= apb.PWDATA[1];
      end else if (wrap && os_q) begin
        en_q <= 1'b0;
      end
    end

    // Prescale and reload registers; ARR keeps only the counter width.
    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        psc_q <= '0;
        arr_q <= '0;
      end else begin
        if (psc_we) psc_q <= apb.PWDATA;
        if (arr_we) arr_q <= apb.PWDATA[CNT_W-1:0];
      end
    end

    // Prescale counter and main counter; both hold while EN is low.
    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        pc_q  <= '0;
        cnt_q <= '0;
      end else if (clr) begin
        pc_q  <= '0;
        cnt_q <= '0;
      end else if (en_q) begin
        if (tick) begin
          pc_q  <= '0;
          cnt_q <= (cnt_q >= arr_q) ? '0 : cnt_q + CNT_W'(1);
        end else begin
          pc_q <= pc_q + 32'd1;
        end
      end
    end
  end

  // Shared status and mask
  logic [NCH-1:0] status;
  logic [NCH-1:0] irq_en;
  logic [NCH-1:0] w1c;

  assign w1c = (wr_acc && glob_sel && (reg_sel == 2'd0)) ? apb.PWDATA[NCH-1:0] : '0;

  // Status: hardware set is ORed in after the W1C so a same-cycle set wins.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      status <= '0;
      irq_en <= '0;
    end else begin
      status <= (status & ~w1c) | ovf;
      if (wr_acc && glob_sel && (reg_sel == 2'd1)) irq_en <= apb.PWDATA[NCH-1:0];
    end
  end

  assign irq = |(status & irq_en);

  // Read mux: zero outside the access phase of a read and for holes.
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (acc && !apb.PWRITE) begin
      if (glob_sel) begin
        if (reg_sel[0]) rdata[NCH-1:0] = irq_en;
        else            rdata[NCH-1:0] = status;
      end else if (ch_sel) begin
        for (int c = 0; c < NCH; c++) begin
          if (ch_idx == 4'(c)) begin
            case (reg_sel)
              2'd0:    rdata[1:0]       = {os_r[c], en_r[c]};
              2'd1:    rdata            = psc_r[c];
              2'd2:    rdata[CNT_W-1:0] = arr_r[c];
              default: rdata[CNT_W-1:0] = cnt_r[c];
            endcase
          end
        end
      end
    end
  end

  assign apb.PRDATA = rdata;

endmodule

// File: tb/tb_apb_timer_multi.sv
// Testbench for apb_timer_multi (NCH=2, CNT_W=8): directed scenarios with
// literal expectations, then random APB traffic against a cycle model.
`timescale 1ns/1ps
module tb_apb_timer_multi;
  localparam int NCH    = 2;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 8;
  localparam int unsigned CNT_MASK = (CNT_W == 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);
  localparam int unsigned CH_MASK  = (32'd1 << NCH) - 32'd1;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b1;
  logic irq;

  apb_timer_multi_if #(.ADDR_W(ADDR_W)) bus ();

  apb_timer_multi #(.NCH(NCH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .apb    (bus),
    .irq    (irq)
  );

  always #5 PCLK = ~PCLK;

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 1'b0;

  logic [31:0] last_rd;
  logic        last_err;
  logic        last_irq;

  // Reference model: registers as plain numbers.
  int unsigned m_status, m_irq_en;
  bit          m_en [NCH];
  bit          m_os [NCH];
  int unsigned m_psc[NCH], m_arr[NCH], m_pc[NCH], m_cnt[NCH];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // 0 = hole, 1 = STATUS, 2 = IRQ_EN, 3 = channel register (ch, off).
  function automatic int region(input logic [ADDR_W-1:0] a, output int ch, output int off);
    int w;
    w   = int'(a) & ~3;
    ch  = 0;
    off = 0;
    if (w == 0) return 1;
    if (w == 4) return 2;
    if (w >= 16 && w < 16 + 16 * NCH) begin
      ch  = (w - 16) / 16;
      off = (w % 16) / 4;
      return 3;
    end
    return 0;
  endfunction

  function automatic int unsigned model_read(input logic [ADDR_W-1:0] a);
    int r, ch, off;
    r = region(a, ch, off);
    case (r)
      1: return m_status;
      2: return m_irq_en;
      3: case (off)
           0: return (int'(m_os[ch]) << 1) | int'(m_en[ch]);
           1: return m_psc[ch];
           2: return m_arr[ch];
           default: return m_cnt[ch];
         endcase
      default: return 0;
    endcase
  endfunction

  // Model advance: hardware counting first from pre-edge state, then the
  // software write overrides it.
  always @(posedge PCLK or negedge PRESETn) begin : model_proc
    int unsigned flags, d;
    int r, ch, off;
    if (!PRESETn) begin
      m_status = 0;
      m_irq_en = 0;
      for (int c = 0; c < NCH; c++) begin
        m_en[c] = 0; m_os[c] = 0;
        m_psc[c] = 0; m_arr[c] = 0; m_pc[c] = 0; m_cnt[c] = 0;
      end
    end else begin
      flags = 0;
      d     = bus.PWDATA;
      r     = region(bus.PADDR, ch, off);
      for (int c = 0; c < NCH; c++) begin
        if (m_en[c]) begin
          if (m_pc[c] >= m_psc[c]) begin
            m_pc[c] = 0;
            if (m_cnt[c] >= m_arr[c]) begin
              m_cnt[c] = 0;
              flags |= (32'd1 << c);
              if (m_os[c]) m_en[c] = 0;
            end else begin
              m_cnt[c] = m_cnt[c] + 1;
            end
          end else begin
            m_pc[c] = m_pc[c] + 1;
          end
        end
      end
      if (bus.PSEL && bus.PENABLE && bus.PWRITE) begin
        case (r)
          1: m_status = m_status & ~d;
          2: m_irq_en = d & CH_MASK;
          3: case (off)
               0: begin
                 m_en[ch] = d[0];
                 m_os[ch] = d[1];
                 if (d[2]) begin
                   m_pc[ch]  = 0;
                   m_cnt[ch] = 0;
                   flags &= ~(32'd1 << ch);
                 end
               end
               1: m_psc[ch] = d;
               2: m_arr[ch] = d & CNT_MASK;
               default: ;
             endcase
          default: ;
        endcase
      end
      m_status = (m_status | flags) & CH_MASK;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge PCLK) begin : cmp_proc
    int r, ch, off;
    logic acc, exp_err;
    logic [31:0] exp_rd;
    if (checking) begin
      acc     = bus.PSEL && bus.PENABLE;
      r       = region(bus.PADDR, ch, off);
      exp_err = acc && (r == 0 || (bus.PWRITE && r == 3 && off == 3));
      exp_rd  = (acc && !bus.PWRITE && r != 0) ? model_read(bus.PADDR) : 32'd0;
      check("PREADY",  32'(bus.PREADY),  32'(acc));
      check("PSLVERR", 32'(bus.PSLVERR), 32'(exp_err));
      check("PRDATA",  bus.PRDATA,       exp_rd);
      check("irq",     32'(irq),         32'((m_status & m_irq_en) != 0));
    end
  end

  // All tasks start and end 1ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic apb_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(negedge PCLK);
    last_err = bus.PSLVERR;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [ADDR_W-1:0] a);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(negedge PCLK);
    last_rd  = bus.PRDATA;
    last_err = bus.PSLVERR;
    last_irq = irq;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0;
    #2 PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    checking = 1'b1;

    // Reset values
    for (int a = 0; a < 16 + 16 * NCH; a += 4) begin
      if (a != 8 && a != 12) begin
        apb_read(ADDR_W'(a));
        check("rst_read", last_rd, 32'd0);
        check("rst_err",  32'(last_err), 32'd0);
      end
    end
    check("rst_irq", 32'(irq), 32'd0);

    // Basic count and irq path: ch0 PSC=3 ARR=4, enable lands at edge E0
    apb_write(8'h04, 32'd1);
    apb_write(8'h14, 32'd3);
    apb_write(8'h18, 32'd4);
    apb_write(8'h10, 32'd1);
    idle(3);
    apb_read(8'h1C);  check("cnt_e4",      last_rd, 32'd1);
    idle(12);
    apb_read(8'h00);  check("status_e18",  last_rd, 32'd0);
                      check("irq_e18",     32'(last_irq), 32'd0);
    apb_read(8'h00);  check("status_e20",  last_rd, 32'd1);
                      check("irq_e20",     32'(last_irq), 32'd1);
    apb_read(8'h1C);  check("cnt_e22",     last_rd, 32'd0);
    apb_write(8'h00, 32'd2);
    apb_read(8'h00);  check("w1c_other",   last_rd, 32'd1);
                      check("irq_kept",    32'(last_irq), 32'd1);
    apb_write(8'h00, 32'd1);
    apb_read(8'h00);  check("w1c_clear",   last_rd, 32'd0);
                      check("irq_cleared", 32'(last_irq), 32'd0);
    apb_write(8'h10, 32'd0);

    // One-shot on ch1: PSC=0 ARR=2
    apb_write(8'h24, 32'd0);
    apb_write(8'h28, 32'd2);
    apb_write(8'h20, 32'd3);
    idle(1);
    apb_read(8'h2C);  check("os_cnt2",     last_rd, 32'd2);
    apb_read(8'h20);  check("os_ctrl",     last_rd, 32'd2);
    apb_read(8'h2C);  check("os_cnt_hold", last_rd, 32'd0);
    apb_read(8'h00);  check("os_status",   last_rd, 32'd2);

    // Flag set beats a same-cycle W1C (ch0 overflows every cycle)
    apb_write(8'h14, 32'd0);
    apb_write(8'h18, 32'd0);
    apb_write(8'h10, 32'd1);
    apb_write(8'h00, 32'd1);
    apb_read(8'h00);  check("set_beats_w1c", last_rd, 32'd3);
    apb_write(8'h10, 32'd4);
    apb_write(8'h00, 32'd3);
    apb_read(8'h00);  check("status_zero",   last_rd, 32'd0);

    // CLR on the overflow edge: ARR=1 wraps two edges after enable
    apb_write(8'h18, 32'd1);
    apb_write(8'h10, 32'd1);
    apb_write(8'h10, 32'd4);
    apb_read(8'h00);  check("clr_no_flag",   last_rd, 32'd0);
    apb_read(8'h1C);  check("clr_cnt",       last_rd, 32'd0);
    apb_read(8'h10);  check("clr_ctrl",      last_rd, 32'd0);

    // Software restart beats the one-shot stop on ch1 (ARR=1)
    apb_write(8'h28, 32'd1);
    apb_write(8'h20, 32'd3);
    apb_write(8'h20, 32'd3);
    apb_read(8'h20);  check("restart_kept",  last_rd, 32'd3);
    apb_read(8'h20);  check("restart_stop",  last_rd, 32'd2);
    apb_write(8'h00, 32'd3);

    // Errors and bounds
    apb_write(8'h30, 32'hFFFF_FFFF); check("err_wr_hole", 32'(last_err), 32'd1);
    apb_read(8'h30);  check("err_rd_hole",   32'(last_err), 32'd1);
                      check("hole_rd_zero",  last_rd, 32'd0);
    apb_write(8'h1C, 32'd5);         check("err_wr_cnt",  32'(last_err), 32'd1);
    apb_read(8'h1C);  check("cnt_unwritten", last_rd, 32'd0);
    apb_write(8'h08, 32'd1);         check("err_wr_0x08", 32'(last_err), 32'd1);
    apb_read(8'h04);  check("irq_en_kept",   last_rd, 32'd1);
    apb_write(8'h18, 32'h1FF);       check("arr_wr_ok",   32'(last_err), 32'd0);
    apb_read(8'h18);  check("arr_trunc",     last_rd, 32'hFF);
    apb_write(8'h17, 32'd7);
    apb_read(8'h14);  check("psc_lowbits",   last_rd, 32'd7);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      int k, blk, off, lo;
      logic [ADDR_W-1:0] a;
      logic [31:0] d;
      k   = int'($urandom_range(0, 9));
      blk = int'($urandom_range(0, 3));
      off = int'($urandom_range(0, 3));
      lo  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : 0;
      a   = ($urandom_range(0, 15) == 0) ? ADDR_W'($urandom) : ADDR_W'(blk * 16 + off * 4 + lo);
      d   = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 6));
      if (k < 4)      apb_write(a, d);
      else if (k < 8) apb_read(a);
      else            idle(int'($urandom_range(1, 6)));
    end

    // Reset in the middle of counting
    apb_write(8'h04, 32'd3);
    apb_write(8'h14, 32'd0);
    apb_write(8'h18, 32'd0);
    apb_write(8'h10, 32'd1);
    idle(2);
    check("irq_before_rst", 32'(irq), 32'd1);
    #3 PRESETn = 1'b0;
    #1 check("irq_in_rst", 32'(irq), 32'd0);
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    apb_read(8'h00);  check("post_rst_status", last_rd, 32'd0);
    apb_read(8'h10);  check("post_rst_ctrl",   last_rd, 32'd0);
    apb_read(8'h1C);  check("post_rst_cnt",    last_rd, 32'd0);
    apb_read(8'h04);  check("post_rst_irq_en", last_rd, 32'd0);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
